// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: FSM state encodings and command priorities.
package count_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // Command priority on every clock edge, 0 = highest.
  localparam int unsigned PRIO_RESET = 0;
  localparam int unsigned PRIO_ABORT = 1;
  localparam int unsigned PRIO_START = 2;
  localparam int unsigned PRIO_HOLD  = 3;
  localparam int unsigned PRIO_TICK  = 4;

endpackage

// File: rtl/count_sequencer_if.sv
// Command/status bundle between a controller (master) and the count sequencer (slave).
interface count_sequencer_if #(
  parameter int WIDTH = 3
) ();

  logic             start;
  logic             abort;
  logic             hold;
  logic             auto_reload;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, abort, hold, auto_reload, limit,
    input  count, busy, done, state
  );

  modport slave (
    input  start, abort, hold, auto_reload, limit,
    output count, busy, done, state
  );

endinterface

// File: rtl/count_sequencer_core.sv
// count_core: WIDTH-bit up-counter datapath; clear wins over increment.
module count_core #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_sequencer.sv
// Start/hold/abort sequencer around count_core, with one-shot and auto-reload modes.
// Optional tick prescaler (ratio PRE_DIV) is enabled by defining CNT_SEQ_PRESCALE_EN.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int PRE_DIV = 4
) (
  input logic               clk,
  input logic               reset,
  count_sequencer_if.slave  bus
);

  if (PRE_DIV < 2) begin : g_bad_pre_div
    $error("count_sequencer: PRE_DIV must be >= 2");
  end

  seq_state_e       state_d;
  seq_state_e       state_q;
  logic [WIDTH-1:0] limit_d;
  logic [WIDTH-1:0] limit_q;
  logic             reload_d;
  logic             reload_q;
  logic             done_d;
  logic             done_q;
  logic             busy_d;
  logic             busy_q;
  logic [WIDTH-1:0] count;
  logic             clr;
  logic             inc;
  logic             start_ok;
  logic             tick;
  logic             presc_hit;

  assign start_ok = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef CNT_SEQ_PRESCALE_EN
  localparam int PW = $clog2(PRE_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIV - 1);

  logic [PW-1:0] presc_d;
  logic [PW-1:0] presc_q;

  assign presc_hit = (presc_q == PRE_LAST);

  // Restarts from zero on every run entry and after each tick; frozen while held.
  always_comb begin
    presc_d = presc_q;
    if (bus.abort || start_ok || tick || (state_q != ST_RUN && state_q != ST_HOLD)) begin
      presc_d = '0;
    end else if (state_q == ST_RUN && !bus.hold) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign presc_hit = 1'b1;
`endif

  assign tick = (state_q == ST_RUN) && !bus.hold && presc_hit;

  always_comb begin
    state_d  = state_q;
    limit_d  = limit_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    clr      = 1'b0;
    inc      = 1'b0;
    if (bus.abort) begin
      state_d = ST_IDLE;
      clr     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          clr = 1'b1;
          if (start_ok) begin
            state_d  = ST_RUN;
            limit_d  = bus.limit;
            reload_d = bus.auto_reload;
          end
        end
        ST_RUN: begin
          if (bus.hold) begin
            state_d = ST_HOLD;
          end else if (tick) begin
            if (count != limit_q) begin
              inc = 1'b1;
            end else begin
              done_d = 1'b1;
              if (reload_q) begin
                clr = 1'b1;
              end else begin
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_HOLD: begin
          if (!bus.hold) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (start_ok) begin
            state_d  = ST_RUN;
            clr      = 1'b1;
            limit_d  = bus.limit;
            reload_d = bus.auto_reload;
          end
        end
        default: begin
          state_d = ST_IDLE;
          clr     = 1'b1;
        end
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      limit_q  <= '0;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      limit_q  <= limit_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc),
    .count (count)
  );

  assign bus.count = count;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: directed scenarios then random commands vs a cycle-count model.
module tb_count_sequencer;

`ifdef CNT_SEQ_PRESCALE_EN
  localparam int TB_DIV = 4;
`else
  localparam int TB_DIV = 1;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  count_sequencer_if #(.WIDTH(3)) bif ();

  count_sequencer #(
    .WIDTH   (3),
    .PRE_DIV (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    int cnt;
    int st;
    bit busy;
    bit done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: 0 idle, 1 running, 2 paused, 3 finished; elapsed counts cycles toward the next tick.
  int m_st, m_cnt, m_lim, m_elapsed;
  bit m_rel, m_done;

  task automatic model_step(input bit r, input bit s, input bit a, input bit h,
                            input bit rl, input int lim, output exp_t e);
    if (r) begin
      m_st = 0; m_cnt = 0; m_lim = 0; m_rel = 0; m_elapsed = 0; m_done = 0;
    end else if (a) begin
      m_st = 0; m_cnt = 0; m_done = 0; m_elapsed = 0;
    end else begin
      m_done = 0;
      if (m_st == 0 || m_st == 3) begin
        if (s) begin
          m_st = 1; m_cnt = 0; m_lim = lim % 8; m_rel = rl; m_elapsed = 0;
        end
      end else if (m_st == 1) begin
        if (h) begin
          m_st = 2;
        end else begin
          m_elapsed = m_elapsed + 1;
          if (m_elapsed == TB_DIV) begin
            m_elapsed = 0;
            if (m_cnt < m_lim) begin
              m_cnt = m_cnt + 1;
            end else begin
              m_done = 1;
              if (m_rel) m_cnt = 0;
              else m_st = 3;
            end
          end
        end
      end else if (m_st == 2) begin
        if (!h) m_st = 1;
      end
    end
    e.cnt  = m_cnt;
    e.st   = m_st;
    e.busy = (m_st == 1) || (m_st == 2);
    e.done = m_done;
  endtask

  task automatic cyc(input bit r, input bit s, input bit a, input bit h,
                     input bit rl, input int lim);
    exp_t e;
    reset           = r;
    bif.start       = s;
    bif.abort       = a;
    bif.hold        = h;
    bif.auto_reload = rl;
    bif.limit       = 3'(lim);
    model_step(r, s, a, h, rl, lim, e);
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic idle_n(input int n, input bit h);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, h, 1'b0, 0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("count", int'(bif.count), mon_e.cnt);
      chk("state", int'(bif.state), mon_e.st);
      chk("busy",  int'(bif.busy),  int'(mon_e.busy));
      chk("done",  int'(bif.done),  int'(mon_e.done));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; bif.start = 0; bif.abort = 0; bif.hold = 0;
    bif.auto_reload = 0; bif.limit = '0;
    m_st = 0; m_cnt = 0; m_lim = 0; m_rel = 0; m_elapsed = 0; m_done = 0;
    #1;
    // T1 reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    // T2 one-shot to 5
    cyc(0, 1, 0, 0, 0, 5);
    idle_n(8 * TB_DIV, 1'b0);
    // T3 auto-reload with limit 2, then abort
    cyc(0, 1, 0, 0, 1, 2);
    idle_n(10 * TB_DIV, 1'b0);
    cyc(0, 0, 1, 0, 0, 0);
    // T4 limit 7, hold for 4 cycles at count 3
    cyc(0, 1, 0, 0, 0, 7);
    idle_n(3 * TB_DIV, 1'b0);
    idle_n(4, 1'b1);
    idle_n(8 * TB_DIV, 1'b0);
    // T5 abort at count 4, then reset mid-run
    cyc(0, 1, 0, 0, 0, 6);
    idle_n(4 * TB_DIV, 1'b0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 6);
    idle_n(3 * TB_DIV, 1'b0);
    cyc(1, 0, 0, 0, 0, 0);
    // T6 limit 0 one-shot; start during RUN with a new limit is ignored
    cyc(0, 1, 0, 0, 0, 0);
    idle_n(2 * TB_DIV, 1'b0);
    cyc(0, 1, 0, 0, 0, 3);
    cyc(0, 1, 0, 0, 1, 6);
    cyc(0, 1, 0, 0, 0, 1);
    idle_n(6 * TB_DIV, 1'b0);
    cyc(0, 1, 0, 0, 0, 1);
    idle_n(9 * TB_DIV, 1'b0);
    // Random commands
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(199) == 0), ($urandom_range(5) == 0), ($urandom_range(39) == 0),
          ($urandom_range(7) == 0), 1'($urandom), int'($urandom_range(7)));
    end
    @(negedge clk);
    @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
